// File: rtl/pin_cmd_scheduler.sv
// Timed pin-configuration command queue. Each command is replayed as four words on
// the shared pincontrol bus, with the waveform word last. The host always takes the bus first.
module pin_cmd_scheduler #(
    parameter int unsigned NPINS = 24,
    parameter int unsigned BASE  = 50,
    parameter int unsigned WPP   = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] host_addr,
    input  logic [15:0] host_data,
    input  logic        host_wr,
    input  logic        host_rd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_pin,
    input  logic [15:0] cmd_wave,
    input  logic [15:0] cmd_freq,
    input  logic [15:0] cmd_phase,
    input  logic [15:0] cmd_ticks,
    input  logic [31:0] cmd_time,
    input  logic        flush,
    output logic [18:0] bus_addr,
    output logic [15:0] bus_data,
    output logic        bus_wr,
    output logic        bus_rd,
    output logic [31:0] time_now,
    output logic [2:0]  qcount,
    output logic        busy,
    output logic        err
);
    localparam int unsigned AW = 19;
    localparam int unsigned DW = 16;
    localparam int unsigned TW = 32;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 3;

    typedef struct packed {
        logic [6:0]    pin;
        logic [DW-1:0] wave;
        logic [DW-1:0] freq;
        logic [DW-1:0] phase;
        logic [DW-1:0] ticks;
        logic [TW-1:0] ctime;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, WAIT, W_FREQ, W_PHASE, W_TICKS, W_WAVE} state_e;

    state_e        state_q, state_d;
    cmd_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] time_q;

    logic          host_c;
    logic          push_c;
    logic          pop_c;
    logic          sched_wr_c;
    logic [AW-1:0] sched_addr_c;
    logic [DW-1:0] sched_data_c;
    logic          err_c;
    cmd_t          head_c;
    cmd_t          cmd_in_c;
    logic [TW-1:0] elapsed_c;
    logic          launch_c;
    logic          bad_pin_c;
    logic [AW-1:0] pin_base_c;

    assign host_c    = host_wr | host_rd;
    assign cmd_ready = reset & (count_q != CW'(DEPTH));
    assign push_c    = cmd_valid & cmd_ready & ~flush;
    assign cmd_in_c  = '{pin: cmd_pin, wave: cmd_wave, freq: cmd_freq,
                         phase: cmd_phase, ticks: cmd_ticks, ctime: cmd_time};

    // Queue head decode; the signed difference keeps launch correct across time_now wrap.
    assign head_c     = mem_q[rd_ptr_q];
    assign elapsed_c  = time_q - head_c.ctime;
    assign launch_c   = ~elapsed_c[TW-1];
    assign bad_pin_c  = 32'(head_c.pin) >= NPINS;
    assign pin_base_c = AW'(BASE) + AW'(head_c.pin) * AW'(WPP);

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= cmd_in_c;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // Any host access freezes the sequencer for that cycle.
    always_comb begin
        state_d      = state_q;
        pop_c        = 1'b0;
        sched_wr_c   = 1'b0;
        sched_addr_c = '0;
        sched_data_c = '0;
        err_c        = 1'b0;
        if (!host_c) begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) state_d = WAIT;
                end
                WAIT: begin
                    if (bad_pin_c) begin
                        pop_c   = 1'b1;
                        err_c   = 1'b1;
                        state_d = IDLE;
                    end else if (launch_c) begin
                        state_d = W_FREQ;
                    end
                end
                W_FREQ: begin
                    sched_wr_c   = 1'b1;
                    sched_addr_c = pin_base_c + AW'(1);
                    sched_data_c = head_c.freq;
                    state_d      = W_PHASE;
                end
                W_PHASE: begin
                    sched_wr_c   = 1'b1;
                    sched_addr_c = pin_base_c + AW'(2);
                    sched_data_c = head_c.phase;
                    state_d      = W_TICKS;
                end
                W_TICKS: begin
                    sched_wr_c   = 1'b1;
                    sched_addr_c = pin_base_c + AW'(3);
                    sched_data_c = head_c.ticks;
                    state_d      = W_WAVE;
                end
                W_WAVE: begin
                    sched_wr_c   = 1'b1;
                    sched_addr_c = pin_base_c;
                    sched_data_c = head_c.wave;
                    pop_c        = 1'b1;
                    state_d      = ((count_q != CW'(1)) || push_c) ? WAIT : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            time_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            time_q   <= time_q + TW'(1);
        end
    end

    // Bus mux: host pass-through, else scheduler word, else all zero; held quiet in reset.
    assign bus_wr   = reset & (host_c ? host_wr : sched_wr_c);
    assign bus_rd   = reset & host_rd;
    assign bus_addr = !reset ? '0 : (host_c ? host_addr : sched_addr_c);
    assign bus_data = !reset ? '0 : (host_c ? host_data : sched_data_c);

    assign time_now = time_q;
    assign qcount   = count_q;
    assign busy     = (state_q == W_FREQ) || (state_q == W_PHASE) ||
                      (state_q == W_TICKS) || (state_q == W_WAVE);
    assign err      = err_c;

endmodule

// File: tb/tb_pin_cmd_scheduler.sv
// Bench for pin_cmd_scheduler: directed scenarios plus random traffic. A queue of
// expected bus words and drops is filled on enqueue and drained by a negedge monitor.
module tb_pin_cmd_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] host_addr;
    logic [15:0] host_data;
    logic        host_wr, host_rd, cmd_valid, cmd_ready, flush;
    logic [6:0]  cmd_pin;
    logic [15:0] cmd_wave, cmd_freq, cmd_phase, cmd_ticks;
    logic [31:0] cmd_time;
    logic [18:0] bus_addr;
    logic [15:0] bus_data;
    logic        bus_wr, bus_rd, busy, err;
    logic [31:0] time_now;
    logic [2:0]  qcount;

    pin_cmd_scheduler dut (
        .clk(clk), .reset(reset), .host_addr(host_addr), .host_data(host_data),
        .host_wr(host_wr), .host_rd(host_rd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_pin(cmd_pin), .cmd_wave(cmd_wave), .cmd_freq(cmd_freq), .cmd_phase(cmd_phase),
        .cmd_ticks(cmd_ticks), .cmd_time(cmd_time), .flush(flush), .bus_addr(bus_addr),
        .bus_data(bus_data), .bus_wr(bus_wr), .bus_rd(bus_rd), .time_now(time_now),
        .qcount(qcount), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [18:0] addr;
        logic [15:0] data;
        bit          first;
        bit          last;
        logic [31:0] ctime;
    } exp_t;

    typedef struct {
        logic [31:0] t;
        logic [18:0] a;
        logic [15:0] d;
    } log_t;

    exp_t        expq[$];
    log_t        wlog[$];
    int          mcount   = 0;
    int          checks   = 0;
    int          failures = 0;
    int          err_seen = 0;
    logic [31:0] tm;

    // Reference timestamp: counts cycles since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) tm <= 32'd0;
        else        tm <= tm + 32'd1;
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at tm=%0d", name, act, req, tm);
        end
    endtask

    function automatic exp_t mk(input bit is_err, input logic [18:0] a, input logic [15:0] d,
                                input bit first, input bit last, input logic [31:0] ct);
        exp_t e;
        e.is_err = is_err; e.addr = a; e.data = d;
        e.first = first; e.last = last; e.ctime = ct;
        return e;
    endfunction

    // Monitor: compare what the DUT shows this cycle, then update the model.
    always @(negedge clk) begin
        int          mc0;
        exp_t        e;
        logic [18:0] base;
        bit          ok;
        if (!reset) begin
            chk("rst_bus", 80'({bus_wr, bus_rd, bus_addr, bus_data}), 80'd0);
            chk("rst_ctl", 80'({busy, err, cmd_ready, qcount, time_now}), 80'd0);
            expq.delete();
            mcount = 0;
        end else begin
            mc0 = mcount;
            chk("time_now", 80'(time_now), 80'(tm));
            chk("cmd_ready", 80'(cmd_ready), 80'(mc0 < 4));
            chk("qcount", 80'(qcount), 80'(mc0));
            if (mc0 == 0) chk("busy_idle", 80'(busy), 80'd0);
            if (host_wr || host_rd) begin
                chk("host_pass", 80'({bus_wr, bus_rd, bus_addr, bus_data}),
                    80'({host_wr, host_rd, host_addr, host_data}));
                chk("err_host", 80'(err), 80'd0);
                if (bus_wr) wlog.push_back('{t: tm, a: bus_addr, d: bus_data});
            end else if (bus_wr) begin
                wlog.push_back('{t: tm, a: bus_addr, d: bus_data});
                chk("busy_wr", 80'(busy), 80'd1);
                ok = (expq.size() > 0) && !expq[0].is_err;
                chk("wr_expected", 80'(ok), 80'd1);
                if (ok) begin
                    e = expq.pop_front();
                    chk("wr_addr_data", 80'({bus_addr, bus_data}), 80'({e.addr, e.data}));
                    if (e.first) chk("launch_time", 80'($signed(tm - e.ctime) > 0), 80'd1);
                    if (e.last) mcount--;
                end
            end else begin
                chk("idle_bus", 80'({bus_rd, bus_addr, bus_data}), 80'd0);
            end
            if (err) begin
                err_seen++;
                ok = (expq.size() > 0) && expq[0].is_err;
                chk("err_expected", 80'(ok), 80'd1);
                if (ok) begin
                    void'(expq.pop_front());
                    mcount--;
                end
            end
            if (cmd_valid && mc0 < 4 && !flush) begin
                if (cmd_pin >= 7'd24) begin
                    expq.push_back(mk(1'b1, 19'd0, 16'd0, 1'b0, 1'b0, cmd_time));
                end else begin
                    base = 19'd50 + 19'(cmd_pin) * 19'd6;
                    expq.push_back(mk(1'b0, base + 19'd1, cmd_freq,  1'b1, 1'b0, cmd_time));
                    expq.push_back(mk(1'b0, base + 19'd2, cmd_phase, 1'b0, 1'b0, cmd_time));
                    expq.push_back(mk(1'b0, base + 19'd3, cmd_ticks, 1'b0, 1'b0, cmd_time));
                    expq.push_back(mk(1'b0, base,         cmd_wave,  1'b0, 1'b1, cmd_time));
                end
                mcount++;
            end
            if (flush) begin
                expq.delete();
                mcount = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] pin, input logic [15:0] wave, input logic [15:0] freq,
                        input logic [15:0] phase, input logic [15:0] ticks, input logic [31:0] t);
        cmd_valid = 1'b1; cmd_pin = pin; cmd_wave = wave; cmd_freq = freq;
        cmd_phase = phase; cmd_ticks = ticks; cmd_time = t;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tm(input logic [31:0] target, input int budget);
        for (int i = 0; i < budget && tm != target; i++) step(1);
        chk("wait_tm", 80'(tm), 80'(target));
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && !(expq.size() == 0 && qcount == 3'd0); i++) step(1);
        chk("drain", 80'({qcount, 16'(expq.size())}), 80'd0);
    endtask

    task automatic chk_log(input int idx, input logic [31:0] t, input logic [18:0] a,
                           input logic [15:0] d);
        if (idx < wlog.size())
            chk("log_entry", {13'd0, wlog[idx].t, wlog[idx].a, wlog[idx].d}, {13'd0, t, a, d});
        else
            chk("log_missing", 80'(wlog.size()), 80'(idx + 1));
    endtask

    initial begin
        logic [31:0] c;
        int          e0;
        reset = 1'b0; host_addr = '0; host_data = '0; host_wr = 1'b0; host_rd = 1'b0;
        cmd_valid = 1'b0; flush = 1'b0; cmd_pin = '0; cmd_wave = '0; cmd_freq = '0;
        cmd_phase = '0; cmd_ticks = '0; cmd_time = '0;
        step(3);
        reset = 1'b1;

        // Reference sequence: pin 3, launch time 20, words on cycles 21..24.
        wlog.delete();
        send(7'd3, 16'd1, 16'h0100, 16'h0000, 16'h0010, 32'd20);
        drain(100);
        chk("req023_n", 80'(wlog.size()), 80'd4);
        chk_log(0, 32'd21, 19'd69, 16'h0100);
        chk_log(1, 32'd22, 19'd70, 16'h0000);
        chk_log(2, 32'd23, 19'd71, 16'h0010);
        chk_log(3, 32'd24, 19'd68, 16'h0001);

        // Host write during W_PHASE stretches the sequence by one cycle.
        wlog.delete();
        c = tm;
        send(7'd0, 16'd2, 16'h000A, 16'h000B, 16'h000C, c + 32'd5);
        wait_tm(c + 32'd7, 50);
        host_wr = 1'b1; host_addr = 19'h40; host_data = 16'h1234;
        step(1);
        host_wr = 1'b0;
        drain(50);
        chk_log(0, c + 32'd6,  19'd51,  16'h000A);
        chk_log(1, c + 32'd7,  19'h40,  16'h1234);
        chk_log(2, c + 32'd8,  19'd52,  16'h000B);
        chk_log(3, c + 32'd9,  19'd53,  16'h000C);
        chk_log(4, c + 32'd10, 19'd50,  16'h0002);

        // Full queue: fifth offer refused; far-future head never launches.
        wlog.delete();
        for (int i = 1; i <= 4; i++)
            send(7'(i), 16'd4, 16'(i), 16'd0, 16'd0, tm + 32'h7FFF_0000);
        cmd_valid = 1'b1; cmd_pin = 7'd5; cmd_time = tm;
        chk("req025_ready", 80'(cmd_ready), 80'd0);
        chk("req025_qcount", 80'(qcount), 80'd4);
        step(1);
        cmd_valid = 1'b0;
        step(20);
        chk("req025_nowr", 80'(wlog.size()), 80'd0);
        flush = 1'b1; cmd_valid = 1'b1; cmd_pin = 7'd6; cmd_time = tm;
        step(1);
        flush = 1'b0; cmd_valid = 1'b0;
        chk("flush_qcount", 80'(qcount), 80'd0);
        step(5);

        // Timestamp more than half the range ahead is treated as already past.
        wlog.delete();
        c = tm;
        send(7'd9, 16'd3, 16'h1111, 16'h2222, 16'h3333, c + 32'h9000_0000);
        drain(50);
        chk_log(0, c + 32'd3, 19'd105, 16'h1111);

        // Out-of-range pin is dropped with an err pulse; next entry runs normally.
        wlog.delete();
        e0 = err_seen;
        c = tm;
        send(7'd30, 16'd1, 16'hDEAD, 16'hBEEF, 16'hCAFE, c);
        send(7'd2, 16'd1, 16'h0042, 16'h0043, 16'h0044, c);
        drain(50);
        chk("req027_err", 80'(err_seen - e0), 80'd1);
        chk("req027_n", 80'(wlog.size()), 80'd4);
        chk_log(0, c + 32'd5, 19'd63, 16'h0042);

        // Flush during W_TICKS: wave word never written.
        wlog.delete();
        c = tm;
        send(7'd5, 16'd1, 16'h0005, 16'h0006, 16'h0007, c + 32'd4);
        wait_tm(c + 32'd7, 50);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("req028_busy", 80'(busy), 80'd0);
        chk("req028_qcount", 80'(qcount), 80'd0);
        step(10);
        chk("req028_n", 80'(wlog.size()), 80'd3);
        chk_log(2, c + 32'd7, 19'd83, 16'h0007);

        // Reset mid-sequence aborts with no further writes.
        wlog.delete();
        c = tm;
        send(7'd7, 16'd1, 16'h0077, 16'h0078, 16'h0079, c + 32'd3);
        wait_tm(c + 32'd5, 50);
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(10);
        chk("req022_n", 80'(wlog.size()), 80'd1);
        chk_log(0, c + 32'd4, 19'd93, 16'h0077);

        // Random traffic with host accesses, bad pins and occasional flushes.
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_pin   = 7'($urandom_range(0, 31));
            cmd_wave  = 16'($urandom_range(1, 4));
            cmd_freq  = 16'($urandom);
            cmd_phase = 16'($urandom);
            cmd_ticks = 16'($urandom);
            cmd_time  = tm + 32'($urandom_range(0, 24)) - 32'd4;
            host_wr   = (r < 6);
            host_rd   = (r >= 6 && r < 10);
            host_addr = 19'($urandom);
            host_data = 16'($urandom);
            flush     = (r == 99);
            step(1);
        end
        cmd_valid = 1'b0; host_wr = 1'b0; host_rd = 1'b0; flush = 1'b0;
        drain(400);
        step(5);
        chk("final_empty", 80'(expq.size()), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
